// File: rtl/id_iset_issue_pkg.sv
// Shared widths, encodings and types for the ID-stage instruction-set issue controller.
package id_iset_issue_pkg;

  localparam int ISET_W = 4;
  localparam int XLEN   = 12;

  typedef logic [ISET_W-1:0] iset_t;
  typedef logic [XLEN-1:0]   word_t;

  localparam iset_t      ISET_BASE   = 4'd0;
  localparam iset_t      ISET_MAX    = 4'd3;
  localparam word_t      NOP         = 12'h000;
  localparam logic [7:0] OP_SETISET  = 8'hFF;
  localparam logic [7:0] OP_ONCEISET = 8'hFE;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_ONESHOT = 1'b1
  } state_e;

  typedef struct packed {
    logic  is_set;
    logic  is_once;
    iset_t operand;
    logic  legal;
  } prefix_t;

  function automatic logic iset_legal(input iset_t x);
    return x <= ISET_MAX;
  endfunction

endpackage

// File: rtl/id_iset_issue_if.sv
// Fetch, EX-control and ID/EX latch signals of the issue controller.
interface id_iset_issue_if;
  import id_iset_issue_pkg::*;

  logic  if_valid;
  word_t if_instr;
  word_t if_pc;
  logic  if_ready;
  logic  ex_stall;
  logic  flush;
  iset_t flush_iset;
  logic  idex_enable;
  word_t idex_instr;
  iset_t idex_iset;
  word_t idex_pc;
  iset_t iset_cur;
  logic  iset_fault;

  modport master (
    output if_valid, if_instr, if_pc, ex_stall, flush, flush_iset,
    input  if_ready, idex_enable, idex_instr, idex_iset, idex_pc, iset_cur, iset_fault
  );

  modport slave (
    input  if_valid, if_instr, if_pc, ex_stall, flush, flush_iset,
    output if_ready, idex_enable, idex_instr, idex_iset, idex_pc, iset_cur, iset_fault
  );
endinterface

// File: rtl/id_iset_issue_prefix_decode.sv
// Combinational classifier for ISET prefix instructions (SETISET / ONCEISET).
module id_iset_issue_prefix_decode
  import id_iset_issue_pkg::*;
(
  input  word_t   instr_i,
  output prefix_t pfx_o
);

  logic [7:0] opcode;

  assign opcode = instr_i[XLEN-1:XLEN-8];

  always_comb begin
    pfx_o         = '0;
    pfx_o.is_set  = (opcode == OP_SETISET);
    pfx_o.is_once = (opcode == OP_ONCEISET);
    pfx_o.operand = instr_i[ISET_W-1:0];
    pfx_o.legal   = iset_legal(instr_i[ISET_W-1:0]);
  end

endmodule

// File: rtl/id_iset_issue.sv
// ID issue controller: tracks the active instruction set, strips prefixes into
// bubbles and drives the ID/EX latch, honouring EX stall and flush.
module id_iset_issue
  import id_iset_issue_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  id_iset_issue_if.slave     bus
);

  state_e  state_q, state_d;
  iset_t   iset_cur_q, iset_cur_d;
  iset_t   temp_q, temp_d;
  logic    fault_q, fault_d;
  prefix_t pfx;
  logic    is_prefix;
  logic    accept;

  id_iset_issue_prefix_decode u_decode (
    .instr_i (bus.if_instr),
    .pfx_o   (pfx)
  );

  assign is_prefix = pfx.is_set | pfx.is_once;
  assign accept    = bus.if_valid & ~bus.ex_stall & ~bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      iset_cur_q <= ISET_BASE;
      temp_q     <= ISET_BASE;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      iset_cur_q <= iset_cur_d;
      temp_q     <= temp_d;
      fault_q    <= fault_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    iset_cur_d = iset_cur_q;
    temp_d     = temp_q;
    fault_d    = fault_q;

    if (bus.flush) begin
      state_d    = ST_RUN;
      iset_cur_d = bus.flush_iset;
      temp_d     = ISET_BASE;
    end else if (accept) begin
      // An illegal prefix only raises the fault; everything else is left alone.
      if (is_prefix && !pfx.legal) begin
        fault_d = 1'b1;
      end else if (pfx.is_set) begin
        iset_cur_d = pfx.operand;
      end else if (pfx.is_once) begin
        temp_d  = pfx.operand;
        state_d = ST_ONESHOT;
      end else begin
        state_d = ST_RUN;
      end
    end
  end

  always_comb begin
    bus.if_ready    = ~bus.ex_stall & ~bus.flush;
    bus.idex_enable = bus.flush | ~bus.ex_stall;
    bus.idex_instr  = NOP;
    bus.idex_iset   = iset_cur_q;
    bus.idex_pc     = bus.if_pc;

    if (bus.flush) begin
      bus.idex_iset = bus.flush_iset;
      bus.idex_pc   = '0;
    end else if (bus.if_valid && !is_prefix) begin
      bus.idex_instr = bus.if_instr;
      bus.idex_iset  = (state_q == ST_ONESHOT) ? temp_q : iset_cur_q;
    end
  end

  assign bus.iset_cur   = iset_cur_q;
  assign bus.iset_fault = fault_q;

endmodule

// File: tb/tb_id_iset_issue.sv
// Directed plus randomized checks of id_iset_issue against a behavioural model.
module tb_id_iset_issue;
  import id_iset_issue_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  id_iset_issue_if bus ();

  id_iset_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: committed set, pending one-shot override, sticky fault.
  logic [3:0] m_cur;
  logic       m_once_pending;
  logic [3:0] m_once_set;
  logic       m_fault;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic is_pfx(input logic [11:0] w);
    return (w[11:4] == 8'hFF) || (w[11:4] == 8'hFE);
  endfunction

  task automatic model_reset();
    m_cur = 4'd0;
    m_once_pending = 1'b0;
    m_once_set = 4'd0;
    m_fault = 1'b0;
  endtask

  // Drive one cycle (called at posedge+1), check combinational outputs, clock, update model,
  // then check the registered set/fault.
  task automatic step(input logic v, input logic [11:0] ins, input logic [11:0] pc,
                      input logic st, input logic fl, input logic [3:0] fis);
    logic [11:0] e_instr, e_pc;
    logic [3:0]  e_iset;
    logic        pfx;
    bus.if_valid = v; bus.if_instr = ins; bus.if_pc = pc;
    bus.ex_stall = st; bus.flush = fl; bus.flush_iset = fis;
    pfx = is_pfx(ins);
    if (fl) begin
      e_instr = 12'h000; e_iset = fis; e_pc = 12'h000;
    end else if (!v || pfx) begin
      e_instr = 12'h000; e_iset = m_cur; e_pc = pc;
    end else begin
      e_instr = ins; e_pc = pc;
      e_iset = m_once_pending ? m_once_set : m_cur;
    end
    #3;
    $display("txn t=%0t v=%0b instr=%h pc=%h stall=%0b flush=%0b -> en=%0b instr=%h iset=%0d pc=%h",
             $time, v, ins, pc, st, fl, bus.idex_enable, bus.idex_instr, bus.idex_iset, bus.idex_pc);
    check("if_ready",    12'(bus.if_ready),    12'(!st && !fl));
    check("idex_enable", 12'(bus.idex_enable), 12'(fl || !st));
    check("idex_instr",  bus.idex_instr,       e_instr);
    check("idex_iset",   12'(bus.idex_iset),   12'(e_iset));
    check("idex_pc",     bus.idex_pc,          e_pc);
    @(posedge clk);
    if (fl) begin
      m_cur = fis; m_once_pending = 1'b0;
    end else if (v && !st) begin
      if (pfx) begin
        if (ins[3:0] > 4'd3) m_fault = 1'b1;
        else if (ins[11:4] == 8'hFF) m_cur = ins[3:0];
        else begin m_once_set = ins[3:0]; m_once_pending = 1'b1; end
      end else begin
        m_once_pending = 1'b0;
      end
    end
    #1;
    check("iset_cur",   12'(bus.iset_cur),   12'(m_cur));
    check("iset_fault", 12'(bus.iset_fault), 12'(m_fault));
  endtask

  // Asynchronous reset mid-cycle, held across one edge with a would-be-accepted SETISET.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    bus.if_valid = 1'b0; bus.if_instr = 12'hFF2; bus.if_pc = 12'h0AB;
    bus.ex_stall = 1'b0; bus.flush = 1'b0; bus.flush_iset = 4'd0;
    #2;
    check("rst_iset_cur",   12'(bus.iset_cur),    12'h000);
    check("rst_iset_fault", 12'(bus.iset_fault),  12'h000);
    check("rst_enable",     12'(bus.idex_enable), 12'h001);
    check("rst_instr",      bus.idex_instr,       12'h000);
    check("rst_iset",       12'(bus.idex_iset),   12'h000);
    check("rst_pc",         bus.idex_pc,          12'h0AB);
    bus.if_valid = 1'b1;
    #1;
    check("rst_ready", 12'(bus.if_ready), 12'h001);
    @(posedge clk);
    #1;
    check("rst_frozen", 12'(bus.iset_cur), 12'h000);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    bus.if_valid = 1'b0; bus.if_instr = '0; bus.if_pc = '0;
    bus.ex_stall = 1'b0; bus.flush = 1'b0; bus.flush_iset = '0;
    @(posedge clk); #1;
    do_reset();

    // Reset release with a plain instruction
    step(1, 12'h123, 12'h010, 0, 0, 0);
    // SETISET 2 then an instruction
    step(1, 12'hFF2, 12'h011, 0, 0, 0);
    step(1, 12'h456, 12'h012, 0, 0, 0);
    // iset_cur 1, ONCEISET 3, two instructions
    step(1, 12'hFF1, 12'h013, 0, 0, 0);
    step(1, 12'hFE3, 12'h014, 0, 0, 0);
    step(1, 12'h111, 12'h015, 0, 0, 0);
    step(1, 12'h222, 12'h016, 0, 0, 0);
    // Stall held three cycles while mid-ONESHOT
    step(1, 12'hFE2, 12'h017, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 12'h333, 12'h018, 1, 0, 0);
    step(1, 12'h333, 12'h018, 0, 0, 0);
    step(1, 12'h334, 12'h019, 0, 0, 0);
    // ONCEISET 2 then flush with stall
    step(1, 12'hFE2, 12'h01A, 0, 0, 0);
    step(1, 12'h444, 12'h01B, 1, 1, 4'd1);
    step(1, 12'h444, 12'h01B, 0, 0, 0);
    // Illegal SETISET 7: sticky fault
    step(1, 12'hFF7, 12'h01C, 0, 0, 0);
    step(1, 12'h555, 12'h01D, 0, 0, 0);
    step(0, 12'h000, 12'h01E, 0, 1, 4'd2);
    step(1, 12'h556, 12'h01F, 0, 0, 0);
    // Reset in the middle of a ONESHOT
    step(1, 12'hFE3, 12'h020, 0, 0, 0);
    do_reset();
    step(1, 12'h777, 12'h021, 0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [11:0] ins;
      int kind;
      kind = int'($urandom_range(0, 9));
      case (kind)
        0, 1:    ins = {8'hFF, 4'($urandom_range(0, 3))};
        2, 3:    ins = {8'hFE, 4'($urandom_range(0, 3))};
        4:       ins = ($urandom_range(0, 7) == 0) ? {8'hFE, 4'($urandom_range(4, 15))}
                                                   : {8'hFF, 4'($urandom_range(0, 3))};
        default: ins = 12'($urandom_range(0, 12'hFDF));
      endcase
      if (n % 130 == 129) do_reset();
      step(1'($urandom_range(0, 5) != 0), ins, 12'($urandom),
           1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 14) == 0),
           4'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
